// File: rtl/cond_pkg.sv
// -----------------------------------------------------------------------------
// cond_pkg
//   Shared definitions for the conditional-execution unit:
//   - cond_e    : the sixteen 4-bit ARM condition codes
//   - *_IDX     : bit positions of N, Z, C and V inside a {N,Z,C,V} nibble
//   - NV_*      : encodings of the NV_MODE parameter (meaning of cond 4'b1111)
// -----------------------------------------------------------------------------
package cond_pkg;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_e;

   localparam int N_IDX = 3;
   localparam int Z_IDX = 2;
   localparam int C_IDX = 1;
   localparam int V_IDX = 0;

   localparam logic NV_NEVER  = 1'b0;
   localparam logic NV_ALWAYS = 1'b1;

endpackage : cond_pkg

// File: rtl/cond_logic_unit_cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
//   Pure combinational evaluation of a 4-bit condition field against one
//   {N,Z,C,V} flag nibble.
//   Ports:
//     cond_i     [3:0]  condition field
//     flags_i    [3:0]  {N,Z,C,V}
//     nv_mode_i         result to return for cond 4'b1111
//     cond_ex_o         1 = instruction executes
// -----------------------------------------------------------------------------
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] cond_i,
   input  logic [3:0] flags_i,
   input  logic       nv_mode_i,
   output logic       cond_ex_o
);

   logic  n_f, z_f, c_f, v_f;
   logic  base;
   cond_e code;

   assign n_f  = flags_i[N_IDX];
   assign z_f  = flags_i[Z_IDX];
   assign c_f  = flags_i[C_IDX];
   assign v_f  = flags_i[V_IDX];
   assign code = cond_e'(cond_i);

   // Codes come in pairs: cond[3:1] picks the base test, cond[0] inverts it.
   // The 1110/1111 pair breaks the pattern, so 1111 is overridden afterwards.
   always_comb begin
      // NOTE: every signal assigned here gets a value before any branch, so
      // no path can leave it unassigned and infer a latch.
      base      = 1'b0;
      cond_ex_o = 1'b0;
      case (cond_i[3:1])
         3'b000: base = z_f;
         3'b001: base = c_f;
         3'b010: base = n_f;
         3'b011: base = v_f;
         3'b100: base = c_f & ~z_f;
         3'b101: base = (n_f == v_f);
         3'b110: base = ~z_f & (n_f == v_f);
         3'b111: base = 1'b1;
      endcase
      cond_ex_o = base ^ cond_i[0];
      if (code == COND_NV) begin
         cond_ex_o = nv_mode_i;
      end
   end

endmodule : cond_eval

// File: rtl/cond_logic_unit.sv
// -----------------------------------------------------------------------------
// cond_logic_unit
//   Conditional-execution unit between decode/ALU and writeback. Keeps one
//   NZCV flag register per context, evaluates the condition field against the
//   instruction's context, gates its write strobes, updates flags under split
//   NZ/CV enables, and registers the result with stall/flush control.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     in_valid, stall, flush     pipeline control
//     in_ctx [CTX_W]             flag context of the instruction
//     cond [4]                   condition field
//     alu_flags [4]              {N,Z,C,V} from the ALU
//     flag_w [2]                 [1] write N,Z   [0] write C,V
//     reg_w, mem_w, pc_s         requested write strobes
//     out_valid, cond_ex_o       registered valid / condition result
//     reg_w_o, mem_w_o, pc_s_o   registered gated strobes
//     dbg_ctx [CTX_W]            debug context select
//     dbg_flags [4]              combinational flag read of dbg_ctx
//     exec_cnt, squash_cnt       saturating executed / squashed counters
// -----------------------------------------------------------------------------
module cond_logic_unit
   import cond_pkg::*;
#(
   parameter int   NUM_CTX = 2,
   parameter int   CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
   parameter logic NV_MODE = NV_NEVER,
   parameter int   CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             stall,
   input  logic             flush,
   input  logic [CTX_W-1:0] in_ctx,
   input  logic [3:0]       cond,
   input  logic [3:0]       alu_flags,
   input  logic [1:0]       flag_w,
   input  logic             reg_w,
   input  logic             mem_w,
   input  logic             pc_s,
   output logic             out_valid,
   output logic             cond_ex_o,
   output logic             reg_w_o,
   output logic             mem_w_o,
   output logic             pc_s_o,
   input  logic [CTX_W-1:0] dbg_ctx,
   output logic [3:0]       dbg_flags,
   output logic [CNT_W-1:0] exec_cnt,
   output logic [CNT_W-1:0] squash_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [3:0]       flags_q [NUM_CTX];
   logic [3:0]       flags_d [NUM_CTX];
   logic [3:0]       sel_flags;
   logic             ctx_ok;
   logic             eval_ex;
   logic             cond_ex;
   logic             accept;

   logic             out_valid_q, out_valid_d;
   logic             cond_ex_q,   cond_ex_d;
   logic             reg_w_q,     reg_w_d;
   logic             mem_w_q,     mem_w_d;
   logic             pc_s_q,      pc_s_d;
   logic [CNT_W-1:0] exec_cnt_q,   exec_cnt_d;
   logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

   // Context selection by explicit match: an in_ctx that matches no context
   // (possible when NUM_CTX is not a power of two) leaves ctx_ok low.
   always_comb begin
      sel_flags = 4'b0000;
      ctx_ok    = 1'b0;
      for (int i = 0; i < NUM_CTX; i++) begin
         if (in_ctx == CTX_W'(i)) begin
            sel_flags = flags_q[i];
            ctx_ok    = 1'b1;
         end
      end
   end

   always_comb begin
      dbg_flags = 4'b0000;
      for (int i = 0; i < NUM_CTX; i++) begin
         if (dbg_ctx == CTX_W'(i)) begin
            dbg_flags = flags_q[i];
         end
      end
   end

   cond_eval u_cond_eval (
      .cond_i    (cond),
      .flags_i   (sel_flags),
      .nv_mode_i (NV_MODE),
      .cond_ex_o (eval_ex)
   );

   assign cond_ex = eval_ex & ctx_ok;
   assign accept  = in_valid & ~stall & ~flush;

   // Flags are read from the registered state, so an instruction is gated by
   // the flags that existed before it; the update is visible one cycle later.
   always_comb begin
      for (int i = 0; i < NUM_CTX; i++) begin
         flags_d[i] = flags_q[i];
         if (accept && cond_ex && (in_ctx == CTX_W'(i))) begin
            if (flag_w[1]) begin
               flags_d[i][N_IDX] = alu_flags[N_IDX];
               flags_d[i][Z_IDX] = alu_flags[Z_IDX];
            end
            if (flag_w[0]) begin
               flags_d[i][C_IDX] = alu_flags[C_IDX];
               flags_d[i][V_IDX] = alu_flags[V_IDX];
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the flag bank is a handful of flops whose reset value is
         // architecturally visible, so it is reset like any other register.
         for (int i = 0; i < NUM_CTX; i++) begin
            flags_q[i] <= 4'b0000;
         end
      end else begin
         flags_q <= flags_d;
      end
   end

   // Output stage: flush clears, stall holds, otherwise load (idle loads 0).
   always_comb begin
      out_valid_d = out_valid_q;
      cond_ex_d   = cond_ex_q;
      reg_w_d     = reg_w_q;
      mem_w_d     = mem_w_q;
      pc_s_d      = pc_s_q;
      if (flush) begin
         out_valid_d = 1'b0;
         cond_ex_d   = 1'b0;
         reg_w_d     = 1'b0;
         mem_w_d     = 1'b0;
         pc_s_d      = 1'b0;
      end else if (!stall) begin
         out_valid_d = in_valid;
         cond_ex_d   = in_valid & cond_ex;
         reg_w_d     = in_valid & cond_ex & reg_w;
         mem_w_d     = in_valid & cond_ex & mem_w;
         pc_s_d      = in_valid & cond_ex & pc_s;
      end
   end

   always_comb begin
      exec_cnt_d   = exec_cnt_q;
      squash_cnt_d = squash_cnt_q;
      if (accept) begin
         if (cond_ex) begin
            if (exec_cnt_q != CNT_MAX) begin
               exec_cnt_d = exec_cnt_q + CNT_W'(1);
            end
         end else begin
            if (squash_cnt_q != CNT_MAX) begin
               squash_cnt_d = squash_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         cond_ex_q    <= 1'b0;
         reg_w_q      <= 1'b0;
         mem_w_q      <= 1'b0;
         pc_s_q       <= 1'b0;
         exec_cnt_q   <= '0;
         squash_cnt_q <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         cond_ex_q    <= cond_ex_d;
         reg_w_q      <= reg_w_d;
         mem_w_q      <= mem_w_d;
         pc_s_q       <= pc_s_d;
         exec_cnt_q   <= exec_cnt_d;
         squash_cnt_q <= squash_cnt_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign cond_ex_o  = cond_ex_q;
   assign reg_w_o    = reg_w_q;
   assign mem_w_o    = mem_w_q;
   assign pc_s_o     = pc_s_q;
   assign exec_cnt   = exec_cnt_q;
   assign squash_cnt = squash_cnt_q;

endmodule : cond_logic_unit
